// File: rtl/hyperram_test_top.sv
// HyperRAM x8 DDR self-test: powers the device up, programs CR0, then writes and reads back
// a short word pattern and reports progress, mismatch count and last read byte.
`timescale 1ns/1ps
module hyperram_test_top #(
    parameter int          POWERUP_CYCLES = 1875,
    parameter int          NUM_WORDS      = 4,
    parameter int          LAT_CKS        = 6,
    parameter logic [15:0] CR0_VALUE      = 16'h8FEF,
    parameter int          TIMEOUT_CKS    = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_port_0,
    output logic [7:0] o_port_1,
    output logic [7:0] o_port_2,
    input  logic [7:0] dram_dq_in,
    output logic [7:0] dram_dq_out,
    output logic       dram_dq_oe_l,
    input  logic       dram_rwds_in,
    output logic       dram_rwds_out,
    output logic       dram_rwds_oe_l,
    output logic       dram_ck,
    output logic       dram_rst_l,
    output logic       dram_cs_l
);

    typedef enum logic [3:0] {
        ST_RESET = 4'd0, ST_PWRUP = 4'd1, ST_CFG = 4'd2,
        ST_WR    = 4'd3, ST_RD    = 4'd4, ST_DONE = 4'd5
    } state_t;

    typedef enum logic [2:0] {
        BUS_IDLE = 3'd0, BUS_CS = 3'd1, BUS_CA = 3'd2, BUS_LAT = 3'd3,
        BUS_DATA = 3'd4, BUS_RDWAIT = 3'd5, BUS_END = 3'd6
    } bus_t;

    localparam logic [15:0] PWR_LAST  = 16'(POWERUP_CYCLES - 1);
    localparam logic [7:0]  LAT_LAST  = 8'(2 * LAT_CKS - 1);
    localparam logic [7:0]  TO_LAST   = 8'(2 * TIMEOUT_CKS - 1);
    localparam logic [7:0]  WORD_LAST = 8'(NUM_WORDS - 1);
    localparam logic [47:0] CR0_CA    = 48'h6000_0100_0000;

    function automatic logic [15:0] pattern_word(input logic [7:0] idx);
        return {idx, ~idx};
    endfunction

    function automatic logic [47:0] make_ca(input logic rw, input logic [31:0] addr);
        return {rw, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    endfunction

    function automatic logic [7:0] ca_byte(input logic [47:0] ca, input logic [2:0] idx);
        case (idx)
            3'd0:    return ca[47:40];
            3'd1:    return ca[39:32];
            3'd2:    return ca[31:24];
            3'd3:    return ca[23:16];
            3'd4:    return ca[15:8];
            3'd5:    return ca[7:0];
            default: return 8'd0;
        endcase
    endfunction

    state_t      state_r, state_s;
    bus_t        bus_r, bus_s;
    logic [15:0] cnt_r, cnt_s;
    logic        ph_r, ph_s;
    logic [7:0]  beat_r, beat_s;
    logic [7:0]  word_r, word_s;
    logic        ck_r, ck_s, cs_l_r, cs_l_s, rst_l_r, rst_l_s;
    logic [7:0]  dq_out_r, dq_out_s;
    logic        dq_oe_l_r, dq_oe_l_s, rwds_out_r, rwds_out_s, rwds_oe_l_r, rwds_oe_l_s;
    logic [1:0]  nbytes_r, nbytes_s;
    logic [7:0]  rd_hi_r, rd_hi_s, rd_lo_r, rd_lo_s;
    logic [7:0]  err_r, err_s, last_lo_r, last_lo_s, port0_r, port0_s;
    logic [7:0]  dq_q_r;
    logic        rwds_q_r, rwds_prev_r;
    logic [47:0] ca_s;
    logic [15:0] data_s;
    logic        mismatch_s, last_word_s, done_s;

    // Sequencer, bus and capture registers; every output pin comes straight from a flop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_RESET;
            bus_r       <= BUS_IDLE;
            cnt_r       <= 16'd0;
            ph_r        <= 1'b0;
            beat_r      <= 8'd0;
            word_r      <= 8'd0;
            ck_r        <= 1'b0;
            cs_l_r      <= 1'b1;
            rst_l_r     <= 1'b0;
            dq_out_r    <= 8'd0;
            dq_oe_l_r   <= 1'b1;
            rwds_out_r  <= 1'b0;
            rwds_oe_l_r <= 1'b1;
            nbytes_r    <= 2'd0;
            rd_hi_r     <= 8'd0;
            rd_lo_r     <= 8'd0;
            err_r       <= 8'd0;
            last_lo_r   <= 8'd0;
            port0_r     <= 8'd0;
            dq_q_r      <= 8'd0;
            rwds_q_r    <= 1'b0;
            rwds_prev_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bus_r       <= bus_s;
            cnt_r       <= cnt_s;
            ph_r        <= ph_s;
            beat_r      <= beat_s;
            word_r      <= word_s;
            ck_r        <= ck_s;
            cs_l_r      <= cs_l_s;
            rst_l_r     <= rst_l_s;
            dq_out_r    <= dq_out_s;
            dq_oe_l_r   <= dq_oe_l_s;
            rwds_out_r  <= rwds_out_s;
            rwds_oe_l_r <= rwds_oe_l_s;
            nbytes_r    <= nbytes_s;
            rd_hi_r     <= rd_hi_s;
            rd_lo_r     <= rd_lo_s;
            err_r       <= err_s;
            last_lo_r   <= last_lo_s;
            port0_r     <= port0_s;
            dq_q_r      <= dram_dq_in;
            rwds_q_r    <= dram_rwds_in;
            rwds_prev_r <= rwds_q_r;
        end
    end

    // Next-state logic: top-level test sequence plus the per-transaction beat engine
    always_comb begin
        state_s     = state_r;
        bus_s       = bus_r;
        cnt_s       = cnt_r;
        ph_s        = ph_r;
        beat_s      = beat_r;
        word_s      = word_r;
        ck_s        = ck_r;
        cs_l_s      = cs_l_r;
        rst_l_s     = rst_l_r;
        dq_out_s    = dq_out_r;
        dq_oe_l_s   = dq_oe_l_r;
        rwds_out_s  = rwds_out_r;
        rwds_oe_l_s = rwds_oe_l_r;
        nbytes_s    = nbytes_r;
        rd_hi_s     = rd_hi_r;
        rd_lo_s     = rd_lo_r;
        err_s       = err_r;
        last_lo_s   = last_lo_r;
        mismatch_s  = 1'b0;
        last_word_s = (word_r == WORD_LAST);
        ca_s        = (state_r == ST_CFG) ? CR0_CA : make_ca(state_r == ST_RD, {24'd0, word_r});
        data_s      = (state_r == ST_CFG) ? CR0_VALUE : pattern_word(word_r);

        case (state_r)
            ST_RESET: begin
                if (cnt_r == PWR_LAST) begin
                    state_s = ST_PWRUP;
                    cnt_s   = 16'd0;
                    rst_l_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_PWRUP: begin
                if (cnt_r == PWR_LAST) begin
                    state_s = ST_CFG;
                    bus_s   = BUS_IDLE;
                    cnt_s   = 16'd0;
                    word_s  = 8'd0;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_CFG, ST_WR, ST_RD: begin
                case (bus_r)
                    BUS_IDLE: begin
                        if (cnt_r == 16'd3) begin
                            cs_l_s   = 1'b0;
                            bus_s    = BUS_CS;
                            cnt_s    = 16'd0;
                            nbytes_s = 2'd0;
                        end else begin
                            cnt_s = cnt_r + 16'd1;
                        end
                    end
                    BUS_CS: begin
                        if (cnt_r == 16'd1) begin
                            bus_s  = BUS_CA;
                            cnt_s  = 16'd0;
                            ph_s   = 1'b0;
                            beat_s = 8'd0;
                        end else begin
                            cnt_s = cnt_r + 16'd1;
                        end
                    end
                    BUS_CA: begin
                        if (!ph_r) begin
                            dq_out_s  = ca_byte(ca_s, beat_r[2:0]);
                            dq_oe_l_s = 1'b0;
                            ph_s      = 1'b1;
                        end else begin
                            ck_s = ~ck_r;
                            ph_s = 1'b0;
                            if (beat_r == 8'd5) begin
                                beat_s = 8'd0;
                                bus_s  = (state_r == ST_CFG) ? BUS_DATA :
                                         (state_r == ST_WR)  ? BUS_LAT  : BUS_RDWAIT;
                            end else begin
                                beat_s = beat_r + 8'd1;
                            end
                        end
                    end
                    BUS_LAT: begin
                        if (!ph_r) begin
                            dq_out_s = 8'd0;
                            ph_s     = 1'b1;
                        end else begin
                            ck_s = ~ck_r;
                            ph_s = 1'b0;
                            if (beat_r == LAT_LAST) begin
                                beat_s = 8'd0;
                                bus_s  = BUS_DATA;
                            end else begin
                                beat_s = beat_r + 8'd1;
                            end
                        end
                    end
                    BUS_DATA: begin
                        if (!ph_r) begin
                            dq_out_s    = (beat_r == 8'd0) ? data_s[15:8] : data_s[7:0];
                            rwds_oe_l_s = (state_r == ST_CFG);
                            rwds_out_s  = 1'b0;
                            ph_s        = 1'b1;
                        end else begin
                            ck_s = ~ck_r;
                            ph_s = 1'b0;
                            if (beat_r == 8'd1) begin
                                bus_s = BUS_END;
                                cnt_s = 16'd0;
                            end else begin
                                beat_s = beat_r + 8'd1;
                            end
                        end
                    end
                    BUS_RDWAIT: begin
                        dq_oe_l_s = 1'b1;
                        // Every RWDS transition from the device marks a new byte on DQ
                        if ((rwds_q_r != rwds_prev_r) && (nbytes_r != 2'd2)) begin
                            if (nbytes_r == 2'd0) begin
                                rd_hi_s = dq_q_r;
                            end else begin
                                rd_lo_s = dq_q_r;
                            end
                            nbytes_s = nbytes_r + 2'd1;
                        end else begin
                            nbytes_s = nbytes_r;
                        end
                        if (ph_r) begin
                            ck_s = ~ck_r;
                            ph_s = 1'b0;
                            if (ck_r && ((nbytes_r == 2'd2) || (beat_r == TO_LAST))) begin
                                bus_s = BUS_END;
                                cnt_s = 16'd0;
                            end else begin
                                beat_s = beat_r + 8'd1;
                            end
                        end else begin
                            ph_s = 1'b1;
                        end
                    end
                    BUS_END: begin
                        dq_oe_l_s   = 1'b1;
                        rwds_oe_l_s = 1'b1;
                        dq_out_s    = 8'd0;
                        rwds_out_s  = 1'b0;
                        if (cnt_r == 16'd0) begin
                            cnt_s = 16'd1;
                            if (state_r == ST_RD) begin
                                if (nbytes_r == 2'd2) begin
                                    last_lo_s  = rd_lo_r;
                                    mismatch_s = ({rd_hi_r, rd_lo_r} != pattern_word(word_r));
                                end else begin
                                    mismatch_s = 1'b1;
                                end
                                if (mismatch_s && (err_r != 8'hFF)) begin
                                    err_s = err_r + 8'd1;
                                end else begin
                                    err_s = err_r;
                                end
                            end else begin
                                mismatch_s = 1'b0;
                            end
                        end else begin
                            cs_l_s = 1'b1;
                            bus_s  = BUS_IDLE;
                            cnt_s  = 16'd0;
                            case (state_r)
                                ST_CFG: begin
                                    state_s = ST_WR;
                                    word_s  = 8'd0;
                                end
                                ST_WR: begin
                                    if (last_word_s) begin
                                        state_s = ST_RD;
                                        word_s  = 8'd0;
                                    end else begin
                                        word_s = word_r + 8'd1;
                                    end
                                end
                                ST_RD: begin
                                    if (last_word_s) begin
                                        state_s = ST_DONE;
                                    end else begin
                                        word_s = word_r + 8'd1;
                                    end
                                end
                                default: begin
                                    state_s = state_r;
                                end
                            endcase
                        end
                    end
                    default: begin
                        bus_s  = BUS_IDLE;
                        cs_l_s = 1'b1;
                    end
                endcase
            end
            ST_DONE: begin
                cs_l_s = 1'b1;
            end
            default: begin
                state_s = ST_RESET;
            end
        endcase

        done_s  = (state_s == ST_DONE);
        port0_s = {done_s, done_s && (err_s == 8'd0), done_s && (err_s != 8'd0), 1'b0, state_s};
    end

    assign o_port_0       = port0_r;
    assign o_port_1       = err_r;
    assign o_port_2       = last_lo_r;
    assign dram_dq_out    = dq_out_r;
    assign dram_dq_oe_l   = dq_oe_l_r;
    assign dram_rwds_out  = rwds_out_r;
    assign dram_rwds_oe_l = rwds_oe_l_r;
    assign dram_ck        = ck_r;
    assign dram_rst_l     = rst_l_r;
    assign dram_cs_l      = cs_l_r;

endmodule

// File: tb/tb_hyperram_test_top.sv
// Bench for hyperram_test_top: a small HyperRAM bus model plus a transaction scoreboard.
`timescale 1ns/1ps
module tb_hyperram_test_top;

    localparam int LAT_CKS   = 6;
    localparam int NUM_WORDS = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] o_port_0, o_port_1, o_port_2;
    logic [7:0] dram_dq_out;
    logic       dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l;
    logic       dram_ck, dram_rst_l, dram_cs_l;
    logic [7:0] dq_drv;
    logic       rwds_drv;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit rwds_en  = 1'b1;

    typedef struct {
        logic [47:0] ca;
        logic [15:0] data;
        logic [7:0]  port1;
        logic [7:0]  port2;
        bit          is_rd;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] mem [0:7];
    logic [47:0] m_ca;
    logic [15:0] m_data;
    int          m_edges;
    bit          m_rwds_bad, m_oe_bad;

    always #40 i_clk = ~i_clk;

    hyperram_test_top dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_port_0       (o_port_0),
        .o_port_1       (o_port_1),
        .o_port_2       (o_port_2),
        .dram_dq_in     (dq_drv),
        .dram_dq_out    (dram_dq_out),
        .dram_dq_oe_l   (dram_dq_oe_l),
        .dram_rwds_in   (rwds_drv),
        .dram_rwds_out  (dram_rwds_out),
        .dram_rwds_oe_l (dram_rwds_oe_l),
        .dram_ck        (dram_ck),
        .dram_rst_l     (dram_rst_l),
        .dram_cs_l      (dram_cs_l)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bus traffic of one complete test run, straight from the pattern definition
    task automatic push_run(input bit resp);
        txn_t t;
        t.ca = 48'h6000_0100_0000; t.data = 16'h8FEF; t.port1 = 8'h00; t.port2 = 8'h00; t.is_rd = 1'b0;
        sb.push_back(t);
        for (int i = 0; i < NUM_WORDS; i++) begin
            t.ca = 48'h2000_0000_0000 | 48'(i);
            t.data = {8'(i), ~8'(i)};
            t.is_rd = 1'b0;
            sb.push_back(t);
        end
        for (int i = 0; i < NUM_WORDS; i++) begin
            t.ca = 48'hA000_0000_0000 | 48'(i);
            t.is_rd = 1'b1;
            t.port1 = resp ? 8'h00 : 8'(i + 1);
            t.port2 = ~8'(i);
            sb.push_back(t);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!o_port_0[7] && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check_eq("done_seen", 64'(o_port_0[7]), 64'(1));
    endtask

    task automatic check_bus_reset(input string tag);
        check_eq({tag, "_cs_l"}, 64'(dram_cs_l), 64'(1));
        check_eq({tag, "_ck"}, 64'(dram_ck), 64'(0));
        check_eq({tag, "_rst_l"}, 64'(dram_rst_l), 64'(0));
        check_eq({tag, "_dq_oe_l"}, 64'(dram_dq_oe_l), 64'(1));
        check_eq({tag, "_rwds_oe_l"}, 64'(dram_rwds_oe_l), 64'(1));
        check_eq({tag, "_dq_out"}, 64'(dram_dq_out), 64'(0));
        check_eq({tag, "_port0"}, 64'(o_port_0), 64'(0));
    endtask

    always @(negedge dram_cs_l) begin
        m_ca = '0; m_data = '0; m_edges = 0; m_rwds_bad = 1'b0; m_oe_bad = 1'b0;
        dq_drv = 8'h00; rwds_drv = 1'b0;
    end

    // Device model: collect bytes on both CK edges, answer reads with RWDS-strobed data
    always @(dram_ck) begin
        if (mon_en && !dram_cs_l) begin
            m_edges++;
            if (m_edges <= 6) begin
                m_ca = {m_ca[39:0], dram_dq_out};
            end else if (m_ca[47]) begin
                if (!dram_dq_oe_l) m_oe_bad = 1'b1;
                if (rwds_en && m_edges == 7 + 2 * LAT_CKS) begin
                    dq_drv = mem[m_ca[2:0]][15:8]; rwds_drv = 1'b1;
                end else if (rwds_en && m_edges == 8 + 2 * LAT_CKS) begin
                    dq_drv = mem[m_ca[2:0]][7:0]; rwds_drv = 1'b0;
                end
            end else if (m_edges > (m_ca[46] ? 6 : 6 + 2 * LAT_CKS)) begin
                m_data = {m_data[7:0], dram_dq_out};
                if (dram_dq_oe_l) m_oe_bad = 1'b1;
                if (m_ca[46] ? !dram_rwds_oe_l : (dram_rwds_oe_l || dram_rwds_out)) m_rwds_bad = 1'b1;
            end
        end
    end

    // Scoreboard: compare each finished transaction against the oldest expected one
    always @(posedge dram_cs_l) begin
        txn_t e;
        if (mon_en) begin
            check_eq("sb_avail", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("ca", 64'(m_ca), 64'(e.ca));
                check_eq("ck_end", 64'(dram_ck), 64'(0));
                if (e.is_rd) begin
                    check_eq("rd_oe", 64'(m_oe_bad), 64'(0));
                    check_eq("port1", 64'(o_port_1), 64'(e.port1));
                    if (rwds_en) check_eq("port2", 64'(o_port_2), 64'(e.port2));
                end else begin
                    check_eq("nedges", 64'(m_edges), 64'(e.ca[46] ? 8 : 8 + 2 * LAT_CKS));
                    check_eq("wdata", 64'(m_data), 64'(e.data));
                    check_eq("rwds", 64'(m_rwds_bad), 64'(0));
                    check_eq("wr_oe", 64'(m_oe_bad), 64'(0));
                    if (!e.ca[46]) mem[m_ca[2:0]] = m_data;
                end
            end
        end
    end

    initial begin
        dq_drv = 8'h00;
        rwds_drv = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

        // Reset held for ~200 ns
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            check_bus_reset("rst");
        end
        @(negedge i_clk);
        push_run(1'b1);
        mon_en = 1'b1;
        i_rst = 1'b0;

        repeat (1874) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_l_low", 64'(dram_rst_l), 64'(0));
        check_eq("port0_reset", 64'(o_port_0), 64'(8'h00));
        @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_l_high", 64'(dram_rst_l), 64'(1));
        check_eq("port0_pwrup", 64'(o_port_0), 64'(8'h01));

        wait_done(6000);
        check_eq("pass_port0", 64'(o_port_0), 64'(8'hC5));
        check_eq("pass_port1", 64'(o_port_1), 64'(8'h00));
        check_eq("pass_port2", 64'(o_port_2), 64'(8'hFC));
        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        check_eq("done_cs_l", 64'(dram_cs_l), 64'(1));
        check_eq("done_ck", 64'(dram_ck), 64'(0));

        // Restart, then abort in the middle of the CR0 transaction
        mon_en = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        check_bus_reset("rerst");
        check_eq("rerst_port1", 64'(o_port_1), 64'(0));
        check_eq("rerst_port2", 64'(o_port_2), 64'(0));
        i_rst = 1'b0;
        for (int k = 0; k < 5000 && dram_cs_l; k++) @(negedge i_clk);
        check_eq("cfg_cs_seen", 64'(dram_cs_l), 64'(0));
        repeat (5) @(negedge i_clk);
        check_eq("abort_pre_oe", 64'(dram_dq_oe_l), 64'(0));
        i_rst = 1'b1;
        @(negedge i_clk);
        check_bus_reset("abort");

        // Device never strobes RWDS: every read must time out
        @(negedge i_clk);
        sb.delete();
        push_run(1'b0);
        rwds_en = 1'b0;
        mon_en = 1'b1;
        i_rst = 1'b0;
        wait_done(12000);
        check_eq("to_port0", 64'(o_port_0), 64'(8'hA5));
        check_eq("to_port1", 64'(o_port_1), 64'(8'h04));
        check_eq("to_sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
